axi_lite_sram_slave: RTL and testbench

- AXI4-Lite responder backed by an internal word-addressed SRAM.
- Serves as the data-memory target for the pipeline's memory-access stage, which acts as the AXI-Lite initiator.
- Independent read and write channel state machines, byte-strobed writes, SLVERR on out-of-window addresses.
- Single outstanding transaction per direction; no bursts.

---
 rtl/axi_lite_sram_slave.sv | 149 ++++++++++++++
 tb/tb_axi_lite_sram_slave.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_sram_slave.sv
// AXI4-Lite responder backed by a word-addressed SRAM with byte strobes.
// Independent write/read FSMs, one outstanding transaction per direction, SLVERR outside the window.
module axi_lite_sram_slave #(
  parameter int unsigned DEPTH_LOG2 = 10,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] awaddr,
  input  logic        awvalid,
  output logic        awready,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wvalid,
  output logic        wready,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready,
  input  logic [31:0] araddr,
  input  logic        arvalid,
  output logic        arready,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rvalid,
  input  logic        rready
);

  localparam int unsigned DEPTH   = 1 << DEPTH_LOG2;
  localparam int unsigned TAG_LSB = DEPTH_LOG2 + 2;

  typedef enum logic {W_IDLE, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;

  logic [31:0] mem [DEPTH];

  w_state_t    w_state;
  r_state_t    r_state;
  logic        aw_latched, w_latched;
  logic [31:0] aw_addr_q, wdata_q;
  logic [3:0]  wstrb_q;

  logic        aw_hs, w_hs, ar_hs, commit, commit_hit, rd_hit;
  logic [31:0] cur_awaddr, cur_wdata;
  logic [3:0]  cur_wstrb;
  logic [DEPTH_LOG2-1:0] widx, ridx;
  logic        unused_addr_bits;

  function automatic logic addr_hit(input logic [31:0] a);
    return a[31:TAG_LSB] == BASE_ADDR[31:TAG_LSB];
  endfunction

  assign awready = ~rst & (w_state == W_IDLE) & ~aw_latched;
  assign wready  = ~rst & (w_state == W_IDLE) & ~w_latched;
  assign arready = ~rst & (r_state == R_IDLE);

  assign aw_hs = awvalid & awready;
  assign w_hs  = wvalid & wready;
  assign ar_hs = arvalid & arready;

  // Commit may use a handshake completing on this very edge, so bypass the latches.
  assign cur_awaddr = aw_hs ? awaddr : aw_addr_q;
  assign cur_wdata  = w_hs ? wdata : wdata_q;
  assign cur_wstrb  = w_hs ? wstrb : wstrb_q;
  assign commit     = (w_state == W_IDLE) & (aw_latched | aw_hs) & (w_latched | w_hs);
  assign commit_hit = addr_hit(cur_awaddr);
  assign widx       = cur_awaddr[TAG_LSB-1:2];
  assign ridx       = araddr[TAG_LSB-1:2];
  assign rd_hit     = addr_hit(araddr);

  assign unused_addr_bits = ^{cur_awaddr[1:0], araddr[1:0]};

  always_ff @(posedge clk) begin
    if (commit && commit_hit) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (cur_wstrb[b]) mem[widx][8*b +: 8] <= cur_wdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      w_state    <= W_IDLE;
      aw_latched <= 1'b0;
      w_latched  <= 1'b0;
      bvalid     <= 1'b0;
      bresp      <= 2'b00;
      aw_addr_q  <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (aw_hs) begin
            aw_addr_q  <= awaddr;
            aw_latched <= 1'b1;
          end
          if (w_hs) begin
            wdata_q   <= wdata;
            wstrb_q   <= wstrb;
            w_latched <= 1'b1;
          end
          if (commit) begin
            aw_latched <= 1'b0;
            w_latched  <= 1'b0;
            bresp      <= commit_hit ? 2'b00 : 2'b10;
            bvalid     <= 1'b1;
            w_state    <= W_RESP;
          end
        end
        W_RESP: begin
          if (bready) begin
            bvalid  <= 1'b0;
            w_state <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // Nonblocking read of mem gives pre-write data when a commit hits the same word.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= R_IDLE;
      rvalid  <= 1'b0;
      rresp   <= 2'b00;
      rdata   <= '0;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (ar_hs) begin
            rdata   <= rd_hit ? mem[ridx] : '0;
            rresp   <= rd_hit ? 2'b00 : 2'b10;
            rvalid  <= 1'b1;
            r_state <= R_DATA;
          end
        end
        R_DATA: begin
          if (rready) begin
            rvalid  <= 1'b0;
            r_state <= R_IDLE;
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_lite_sram_slave.sv
// Self-checking bench: transaction-level memory model compared every cycle,
// plus directed literal checks and randomized concurrent read/write traffic.
module tb_axi_lite_sram_slave;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] awaddr = '0, wdata = '0, araddr = '0;
  logic [3:0]  wstrb = '0;
  logic        awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
  logic        awready, wready, bvalid, arready, rvalid;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata;

  int unsigned n_cmp = 0, n_fail = 0;

  axi_lite_sram_slave #(.DEPTH_LOG2(10), .BASE_ADDR(32'h0000_0000)) dut (
    .clk(clk), .rst(rst),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: memory array, pending-response flags, accepted-channel flags.
  logic [31:0] m_mem [1024];
  logic        m_ready = 1'b0;
  logic        m_bpend, m_rpend, m_aw_have, m_w_have;
  logic [31:0] m_awaddr, m_wdata, m_rdata;
  logic [3:0]  m_wstrb;
  logic [1:0]  m_bresp, m_rresp;

  function automatic logic in_win(input logic [31:0] a);
    return a[31:12] == 20'h0;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_bpend = 0; m_rpend = 0; m_aw_have = 0; m_w_have = 0;
      m_bresp = 0; m_rresp = 0; m_rdata = 0; m_ready = 1;
    end else if (m_ready) begin
      if (m_rpend) begin
        if (rready) m_rpend = 0;
      end else if (arvalid) begin
        m_rpend = 1;
        m_rdata = in_win(araddr) ? m_mem[araddr[11:2]] : 32'h0;
        m_rresp = in_win(araddr) ? 2'b00 : 2'b10;
      end
      if (m_bpend) begin
        if (bready) m_bpend = 0;
      end else begin
        if (!m_aw_have && awvalid) begin m_aw_have = 1; m_awaddr = awaddr; end
        if (!m_w_have && wvalid) begin m_w_have = 1; m_wdata = wdata; m_wstrb = wstrb; end
        if (m_aw_have && m_w_have) begin
          if (in_win(m_awaddr))
            for (int i = 0; i < 4; i++)
              if (m_wstrb[i]) m_mem[m_awaddr[11:2]][8*i +: 8] = m_wdata[8*i +: 8];
          m_bresp = in_win(m_awaddr) ? 2'b00 : 2'b10;
          m_bpend = 1; m_aw_have = 0; m_w_have = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (m_ready) begin
      chk("awready", awready, !rst && !m_bpend && !m_aw_have);
      chk("wready",  wready,  !rst && !m_bpend && !m_w_have);
      chk("arready", arready, !rst && !m_rpend);
      chk("bvalid",  bvalid,  m_bpend);
      chk("bresp",   bresp,   m_bresp);
      chk("rvalid",  rvalid,  m_rpend);
      chk("rresp",   rresp,   m_rresp);
      chk("rdata",   rdata,   m_rdata);
    end
  end

  // Tasks start right after an active edge and return right after one.
  task automatic run_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int unsigned aw_dly, input int unsigned w_dly,
                           input int unsigned b_dly, output logic [1:0] resp);
    int unsigned cyc = 0;
    bit aw_done = 0, w_done = 0, b_done = 0, aw_go, w_go, b_go;
    resp = 2'bxx;
    awaddr = a; wdata = d; wstrb = s;
    awvalid = (aw_dly == 0); wvalid = (w_dly == 0); bready = (b_dly == 0);
    while (!b_done && cyc < 200) begin
      @(negedge clk);
      aw_go = awvalid && awready; w_go = wvalid && wready; b_go = bvalid && bready;
      if (b_go) resp = bresp;
      @(posedge clk); #1; cyc++;
      if (aw_go) begin awvalid = 0; aw_done = 1; end
      if (w_go) begin wvalid = 0; w_done = 1; end
      if (b_go) begin bready = 0; b_done = 1; end
      if (!aw_done && cyc >= aw_dly) awvalid = 1;
      if (!w_done && cyc >= w_dly) wvalid = 1;
      if (!b_done && cyc >= b_dly) bready = 1;
    end
    if (!b_done) begin
      chk("write_timeout", 32'd0, 32'd1);
      awvalid = 0; wvalid = 0; bready = 0;
    end
  endtask

  task automatic run_read(input logic [31:0] a, input int unsigned ar_dly, input int unsigned r_dly,
                          output logic [31:0] d, output logic [1:0] resp);
    int unsigned cyc = 0;
    bit ar_done = 0, r_done = 0, ar_go, r_go;
    d = 'x; resp = 2'bxx;
    araddr = a; arvalid = (ar_dly == 0); rready = (r_dly == 0);
    while (!r_done && cyc < 200) begin
      @(negedge clk);
      ar_go = arvalid && arready; r_go = rvalid && rready;
      if (r_go) begin d = rdata; resp = rresp; end
      @(posedge clk); #1; cyc++;
      if (ar_go) begin arvalid = 0; ar_done = 1; end
      if (r_go) begin rready = 0; r_done = 1; end
      if (!ar_done && cyc >= ar_dly) arvalid = 1;
      if (!r_done && cyc >= r_dly) rready = 1;
    end
    if (!r_done) begin
      chk("read_timeout", 32'd0, 32'd1);
      arvalid = 0; rready = 0;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  br, rr;
    logic [31:0] rd, a, ra, d;
    logic [3:0]  s;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("reset_bvalid", bvalid, 0);
    chk("reset_rvalid", rvalid, 0);
    chk("reset_rdata", rdata, 0);
    @(posedge clk); #1;

    // Give every word a known value so later reads compare against defined data.
    for (int unsigned i = 0; i < 1024; i++) run_write(i * 4, $urandom, 4'hF, 0, 0, 0, br);

    run_write(32'h10, 32'hDEADBEEF, 4'hF, 0, 0, 0, br);
    chk("t1_bresp", br, 2'b00);
    run_read(32'h10, 0, 0, rd, rr);
    chk("t1_rdata", rd, 32'hDEADBEEF);
    chk("t1_rresp", rr, 2'b00);

    run_write(32'h0, 32'h11223344, 4'hF, 0, 0, 0, br);
    run_write(32'h0, 32'h000000AA, 4'b0001, 3, 0, 0, br);
    chk("t2_bresp", br, 2'b00);
    run_read(32'h0, 0, 0, rd, rr);
    chk("t2_rdata", rd, 32'h112233AA);

    run_write(32'h1000, 32'hCAFEF00D, 4'hF, 0, 0, 0, br);
    chk("t3_bresp", br, 2'b10);
    run_read(32'h1000, 0, 0, rd, rr);
    chk("t3_rresp", rr, 2'b10);
    chk("t3_rdata", rd, 32'h0);
    run_read(32'h0, 0, 0, rd, rr);
    chk("t3_word0", rd, 32'h112233AA);

    fork
      run_write(32'h44, 32'h0BADC0DE, 4'hF, 0, 0, 6, br);
      run_read(32'h10, 0, 6, rd, rr);
    join
    chk("t4_bresp", br, 2'b00);
    chk("t4_rdata", rd, 32'hDEADBEEF);

    run_write(32'h20, 32'h5, 4'hF, 0, 0, 0, br);
    fork
      run_write(32'h20, 32'h9, 4'hF, 0, 0, 0, br);
      run_read(32'h20, 0, 0, rd, rr);
    join
    chk("t5_collide", rd, 32'h5);
    run_read(32'h20, 0, 0, rd, rr);
    chk("t5_after", rd, 32'h9);

    awaddr = 32'h40; wdata = 32'h12345678; wstrb = 4'hF; araddr = 32'h44;
    awvalid = 1; wvalid = 1; arvalid = 1; bready = 0; rready = 0;
    @(posedge clk); #1;
    awvalid = 0; wvalid = 0; arvalid = 0;
    @(negedge clk);
    chk("t6_bvalid_pre", bvalid, 1);
    chk("t6_rvalid_pre", rvalid, 1);
    @(posedge clk); #1 rst = 1;
    @(negedge clk);
    chk("t6_awready_rst", awready, 0);
    chk("t6_arready_rst", arready, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("t6_bvalid_rst", bvalid, 0);
    chk("t6_rvalid_rst", rvalid, 0);
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
    chk("t6_wready_post", wready, 1);
    chk("t6_arready_post", arready, 1);
    @(posedge clk); #1;
    run_read(32'h40, 0, 0, rd, rr);
    chk("t6_read", rd, 32'h12345678);

    for (int unsigned n = 0; n < 300; n++) begin
      a = $urandom; ra = $urandom; d = $urandom; s = 4'($urandom);
      if ($urandom_range(7) != 0) a = {20'h0, a[11:0]};
      if ($urandom_range(7) != 0) ra = {20'h0, ra[11:0]};
      fork
        run_write(a, d, s, $urandom_range(4), $urandom_range(4), $urandom_range(4), br);
        run_read(ra, $urandom_range(4), $urandom_range(4), rd, rr);
      join
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
